// File: rtl/common.sv
// Shared instruction-bus types used by the fetch path and the bus agents.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage types for the fetch queue: FSM encoding and queue entry layout.
package pipes;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetchq_state_t;

  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetchq_entry_t;

  localparam u64 FETCH_STEP = 64'd4;

endpackage

// File: rtl/fetchq_fifo.sv
// Circular {pc, instr} store for the fetch queue; DEPTH must be a power of two
// so the pointers wrap by natural overflow.
module fetchq_fifo
  import pipes::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetchq_entry_t                wdata,
  input  logic                         pop,
  output fetchq_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetchq_entry_t  mem [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: single-outstanding bus fetcher feeding a FIFO to decode.
// Optional same-cycle response bypass to decode when built with FETCHQ_BYPASS_EN.
module fetch_queue
  import common::*;
  import pipes::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetchq_state_t  state;
  fetchq_state_t  state_nxt;
  logic [63:0]    fetch_pc;
  logic [63:0]    fetch_pc_nxt;
  logic [63:0]    stale_addr;
  fetchq_entry_t  fifo_head;
  fetchq_entry_t  fifo_wdata;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  count_after;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic           accept;
  logic           bypass;

  assign accept = (state == REQ) && iresp.data_ok && !redirect_valid;

`ifdef FETCHQ_BYPASS_EN
  assign bypass    = accept && fifo_empty;
  assign out_pc    = fifo_empty ? fetch_pc : fifo_head.pc;
  assign out_instr = fifo_empty ? iresp.data : fifo_head.instr;
`else
  assign bypass    = 1'b0;
  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;
`endif

  // A bypassed response that decode takes immediately never occupies a slot.
  assign out_valid   = !redirect_valid && (!fifo_empty || bypass);
  assign fifo_pop    = out_valid && out_ready && !fifo_empty;
  assign fifo_push   = accept && !(bypass && out_ready);
  assign fifo_wdata  = '{pc: fetch_pc, instr: iresp.data};
  assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    ireq         = '0;
    unique case (state)
      IDLE: begin
        if (fifo_count < CW'(DEPTH)) state_nxt = REQ;
      end
      REQ: begin
        ireq.valid = 1'b1;
        ireq.addr  = fetch_pc;
        if (redirect_valid) begin
          state_nxt = iresp.data_ok ? IDLE : DROP;
        end else if (iresp.data_ok) begin
          fetch_pc_nxt = fetch_pc + FETCH_STEP;
          state_nxt    = (count_after < CW'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        // Keep the abandoned request stable until the bus retires it.
        ireq.valid = 1'b1;
        ireq.addr  = stale_addr;
        if (iresp.data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) fetch_pc_nxt = redirect_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      stale_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if ((state == REQ) && redirect_valid && !iresp.data_ok) stale_addr <= fetch_pc;
    end
  end

  fetchq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios push expected decode entries,
// a negedge monitor pops and compares whenever decode accepts an entry.
module tb_fetch_queue;
  import common::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned lat = 0;
  int unsigned wcnt;
  logic [63:0] sb_pc[$];
  logic [63:0] acc_addr[$];
  logic        prev_pending;
  logic [63:0] prev_addr;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  // Bus agent: responds after lat wait cycles; drops anything pending on reset.
  always_comb begin
    iresp.data_ok = ireq.valid && (wcnt == lat);
    iresp.data    = instr_of(ireq.addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (!ireq.valid || iresp.data_ok) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] acc_at(input int i);
    if (i < acc_addr.size()) return acc_addr[i];
    return 'x;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_pc.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got pc %0h expected no entry", out_pc);
      end else begin
        automatic logic [63:0] e = sb_pc.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_instr", 64'(out_instr), 64'(instr_of(e)));
      end
    end
  end

  // Bus monitor: logs accepted addresses and checks request stability while pending
  always @(negedge clk) begin
    if (reset) begin
      prev_pending <= 1'b0;
    end else begin
      if (prev_pending) begin
        chk("ireq_hold_valid", 64'(ireq.valid), 64'd1);
        chk("ireq_hold_addr", ireq.addr, prev_addr);
      end
      if (ireq.valid && iresp.data_ok) acc_addr.push_back(ireq.addr);
      prev_pending <= ireq.valid && !iresp.data_ok;
      prev_addr    <= ireq.addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int unsigned l, input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    lat            = l;
    tick(2);
    sb_pc.delete();
    acc_addr.delete();
    reset = 1'b0;
  endtask

  task automatic wait_sb_empty(input int lim, input string name);
    int i = 0;
    while (sb_pc.size() != 0 && i < lim) begin
      tick(1);
      i++;
    end
    if (sb_pc.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, %0d entries never presented, expected 0", name, sb_pc.size());
    end
  endtask

  task automatic wait_acc(input int n, input int lim, input string name);
    int i = 0;
    while (acc_addr.size() < n && i < lim) begin
      tick(1);
      i++;
    end
    if (acc_addr.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d accepts expected %0d", name, acc_addr.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and zero-wait streaming
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    lat       = 0;
    #1;
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count), 64'd0);
    tick(1);
    sb_pc.push_back(64'h8000_0000);
    sb_pc.push_back(64'h8000_0004);
    sb_pc.push_back(64'h8000_0008);
    reset = 1'b0;
    tick(1);
    chk("first_req_valid", 64'(ireq.valid), 64'd1);
    chk("first_req_addr", ireq.addr, 64'h8000_0000);
`ifndef FETCHQ_BYPASS_EN
    chk("nobypass_out_valid", 64'(out_valid), 64'd0);
    tick(1);
`endif
    for (int k = 0; k < 3; k++) begin
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
      tick(1);
    end
    out_ready = 1'b0;
    wait_sb_empty(5, "stream_drain");

    // Backpressure: FIFO fills to DEPTH, then one pop admits one fetch
    do_reset(0, 1'b0);
    tick(12);
    chk("full_accepts", 64'(acc_addr.size()), 64'd4);
    chk("full_last_addr", acc_at(3), 64'h8000_000c);
    chk("full_ireq_idle", 64'(ireq.valid), 64'd0);
    chk("full_count", 64'(dut.u_fifo.count), 64'd4);
    sb_pc.push_back(64'h8000_0000);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    wait_sb_empty(2, "full_pop");
    tick(6);
    chk("refill_accepts", 64'(acc_addr.size()), 64'd5);
    chk("refill_addr", acc_at(4), 64'h8000_0010);
    chk("refill_count", 64'(dut.u_fifo.count), 64'd4);
    chk("refill_ireq_idle", 64'(ireq.valid), 64'd0);

    // Redirect during the 2nd wait cycle of a 3-cycle-latency response
    do_reset(3, 1'b1);
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick(1);
    redirect_valid = 1'b0;
    chk("drop_valid", 64'(ireq.valid), 64'd1);
    chk("drop_stale_addr", ireq.addr, 64'h8000_0000);
    sb_pc.push_back(64'h8000_0100);
    wait_acc(2, 20, "drop_accepts");
    chk("drop_acc0", acc_at(0), 64'h8000_0000);
    chk("drop_acc1", acc_at(1), 64'h8000_0100);
    wait_sb_empty(10, "drop_drain");
    out_ready = 1'b0;

    // Redirect coincident with data_ok, one entry queued; target wraps past 2^64
    do_reset(1, 1'b0);
    tick(4);
    chk("coinc_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("coinc_count_before", 64'(dut.u_fifo.count), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_fffc;
    #1;
    chk("coinc_out_forced", 64'(out_valid), 64'd0);
    tick(1);
    redirect_valid = 1'b0;
    chk("coinc_count_after", 64'(dut.u_fifo.count), 64'd0);
    chk("coinc_out_valid", 64'(out_valid), 64'd0);
    sb_pc.push_back(64'hffff_ffff_ffff_fffc);
    sb_pc.push_back(64'h0);
    out_ready = 1'b1;
    wait_sb_empty(20, "coinc_drain");
    out_ready = 1'b0;
    chk("coinc_acc2", acc_at(2), 64'hffff_ffff_ffff_fffc);
    chk("coinc_acc3", acc_at(3), 64'h0);

    // Two redirects while dropping: only the last target is fetched
    do_reset(4, 1'b1);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick(1);
    redirect_valid = 1'b0;
    sb_pc.push_back(64'h200);
    wait_acc(2, 30, "dbl_accepts");
    chk("dbl_acc0", acc_at(0), 64'h8000_0000);
    chk("dbl_acc1", acc_at(1), 64'h200);
    wait_sb_empty(10, "dbl_drain");
    out_ready = 1'b0;

    // Asynchronous reset mid-request with two entries queued
    do_reset(1, 1'b0);
    tick(5);
    chk("mid_count", 64'(dut.u_fifo.count), 64'd2);
    chk("mid_ireq_valid", 64'(ireq.valid), 64'd1);
    chk("mid_out_valid", 64'(out_valid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(dut.u_fifo.count), 64'd0);
    tick(2);
    acc_addr.delete();
    sb_pc.push_back(64'h8000_0000);
    out_ready = 1'b1;
    reset     = 1'b0;
    tick(1);
    chk("post_rst_valid", 64'(ireq.valid), 64'd1);
    chk("post_rst_addr", ireq.addr, 64'h8000_0000);
    wait_sb_empty(10, "post_rst_drain");
    out_ready = 1'b0;
    chk("post_rst_acc0", acc_at(0), 64'h8000_0000);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ireq  out  ibus_req_t  instruction bus request (valid, addr).
REQ-006 iresp  in  ibus_resp_t  instruction bus response (data_ok, data[31:0]).
REQ-007 redirect_valid  in  1  control-flow redirect from execute, one-cycle pulse.
REQ-008 redirect_pc  in  64  redirect target address.
REQ-009 out_valid  out  1  head entry presented to decode.
REQ-010 out_pc  out  64  PC of head entry.
REQ-011 out_instr  out  32  instruction of head entry.
REQ-012 out_ready  in  1  decode accepts head; pop when out_valid && out_ready.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular FIFO of {pc, instr} with wrapping head/tail pointers and a count of width $clog2(DEPTH+1).
REQ-014 fetch_pc SHALL advance by 4 (64-bit wrap) on each accepted, non-discarded response.
REQ-015 At most one bus request SHALL be outstanding; ireq.valid and ireq.addr SHALL stay stable until iresp.data_ok.
REQ-016 FSM states: IDLE, REQ, DROP.
REQ-017 IDLE->REQ when count + (push pending ? 1 : 0) < DEPTH; else stay IDLE with ireq.valid=0.
REQ-018 REQ: ireq.valid=1, addr=fetch_pc; on data_ok without redirect, push {fetch_pc, data} and go to REQ if a slot remains after this push and any same-cycle pop, else IDLE.
REQ-019 REQ with redirect_valid and no data_ok -> DROP; fetch_pc <= redirect_pc.
REQ-020 DROP: ireq.valid=1 with the stale addr; on data_ok discard the data and go to IDLE; further redirects in DROP SHALL overwrite fetch_pc.
REQ-021 Redirect with data_ok in the same cycle: the response SHALL be discarded; fetch_pc <= redirect_pc; next state IDLE.
REQ-022 Redirect in any state SHALL flush the FIFO (count=0, head=tail) at the next edge, and out_valid SHALL be forced to 0 combinationally during the redirect cycle.
REQ-023 Simultaneous push and pop with the FIFO full SHALL be impossible by REQ-017; with the FIFO non-full, push and pop SHALL both occur and count SHALL be unchanged.
REQ-024 Pop when empty SHALL have no effect.

Reset
REQ-025 On reset: state=IDLE, fetch_pc=RESET_PC, count=0, head=tail=0, ireq.valid=0, out_valid=0. The first request SHALL be issued in the cycle after reset deasserts.
REQ-026 Reset asserted with a request outstanding SHALL abandon it; the bus is required to drop the pending response on reset.

Configuration
REQ-027 FETCHQ_BYPASS_EN defined: with the FIFO empty and an accepted response, out_valid/out_pc/out_instr SHALL present the response in the same cycle; if out_ready is also 1, the entry SHALL NOT be written.
REQ-028 FETCHQ_BYPASS_EN undefined: a response SHALL first appear on out_valid one cycle after data_ok.

Structure
REQ-029 fetchq_state_t enum and the fetchq_entry_t struct {u64 pc; u32 instr;} SHALL live in package pipes; ibus types come from common.
REQ-030 One sub-module SHALL be used: fetchq_fifo (parametrised storage, pointers, count); the FSM and bypass logic SHALL stay in fetch_queue.

Verification
REQ-031 Reset, zero-wait bus, out_ready=1: out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles (bypass on) or offset by one cycle (bypass off).
REQ-032 out_ready=0 with DEPTH=4: exactly 4 responses accepted, then ireq.valid=0; count=4; one pop causes one new request.
REQ-033 Bus with a 3-cycle data_ok delay and redirect_pc=0x8000_0100 in the 2nd wait cycle: stale data is dropped, next ireq.addr=0x8000_0100, and no stale entry is ever presented.
REQ-034 Redirect coincident with data_ok: the data is not pushed, the FIFO is empty next cycle, and the next request goes to redirect_pc.
REQ-035 Two redirects in DROP (0x100, then 0x200): the only subsequent fetch is 0x200.
REQ-036 Reset asserted mid-REQ with 2 entries queued: all outputs return to reset values asynchronously, and the first request after release is to 0x8000_0000.
